alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Issue/decode front end that drives the team's combinational 16-bit ALU and captures its outputs.
- Accepts operation requests over a valid/ready handshake and decodes each class code into the 4-bit ALU control word (invertA, invertB, sel[1:0]).
- Sequences one or two ALU passes per request, then returns result and flags over a second valid/ready handshake.
- Also keeps a sticky overflow status and a completed-operation counter.

Parameters:
- W, 16, operand and result width. Fixed to the ALU width; other values are unsupported.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_valid_i and in_ready_o are both high at an edge
- op_i  in  4  class: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 NOR, 5 NAND, 6 SLT, 8 ABSDIFF, 9 MAX, 10 MIN; all other codes illegal
- src1_i  in  W  operand A
- src2_i  in  W  operand B
- alu_src1_o  out  W  ALU operand A
- alu_src2_o  out  W  ALU operand B
- alu_ctrl_o  out  4  ALU control word
- alu_result_i  in  W  ALU result, combinational, same cycle
- alu_zero_i  in  1  ALU zero flag
- alu_overflow_i  in  1  ALU overflow flag
- out_valid_o  out  1  response valid
- out_ready_i  in  1  response consumed when out_valid_o and out_ready_i are both high at an edge
- result_o  out  W  registered result
- zero_o  out  1  registered zero flag
- overflow_o  out  1  registered overflow flag
- err_o  out  1  illegal opcode marker, qualified by out_valid_o
- ovf_sticky_o  out  1  sticky overflow status
- ovf_clr_i  in  1  clears ovf_sticky_o
- op_count_o  out  CNT_W  number of completed responses

Behaviour:
- Decode to alu_ctrl_o:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, NAND 1101, SLT 0111.
  - Carry-in equals invertB inside the ALU, so SUB and SLT need no extra carry handling here.
- States:
  - IDLE: accepts a request.
  - EXEC: first ALU pass.
  - EXEC2: second ALU pass.
  - Outside EXEC/EXEC2: alu_src1_o = alu_src2_o = 0 and alu_ctrl_o = 0000.
- in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i). It is combinational and depends on out_ready_i only.
- Accept edge: op, src1 and src2 are latched and the block moves to EXEC.
- Single-pass ops (codes 0–6):
  - EXEC drives the latched operands and decoded control.
  - At the end of EXEC, alu_result_i, alu_zero_i and alu_overflow_i are registered into the output registers.
  - out_valid_o rises; the block returns to IDLE.
  - Latency: out_valid_o is high one cycle after the accept edge.
- ABSDIFF, MAX, MIN (two passes):
  - EXEC runs SLT(A,B); lt = alu_result_i[0] is registered; the block moves to EXEC2.
  - EXEC2 for ABSDIFF: SUB with operands swapped when lt=1 (B−A), otherwise A−B.
  - EXEC2 for MAX: OR(lt ? B : A, 0). For MIN: OR(lt ? A : B, 0).
  - Result and zero are captured from EXEC2. overflow_o is the EXEC2 overflow for ABSDIFF and is forced to 0 for MAX/MIN.
  - Latency: out_valid_o is high two cycles after the accept edge.
- Illegal opcode:
  - Still spends one EXEC cycle, with ALU outputs driven to idle values.
  - Response: result_o=0, zero_o=1, overflow_o=0, err_o=1.
  - err_o=0 for all legal ops.
- Response holding and draining:
  - out_valid_o and the response registers hold while out_ready_i is low.
  - out_valid_o clears on a consume edge unless a new response is captured on the same edge; capture wins.
  - A response capture only occurs when the output slot is free or draining, guaranteed by in_ready_o.
- ovf_sticky_o:
  - Set on any capture with overflow_o=1 for ADD, SUB or ABSDIFF. SLT passes never set it.
  - ovf_clr_i clears it. If set and clear occur on the same edge, set wins.
- op_count_o increments at each response capture, illegal opcodes included, and wraps from all-ones to 0.
- Reset (async, active-low) values: state=IDLE, out_valid_o=0, result_o=0, zero_o=0, overflow_o=0, err_o=0, ovf_sticky_o=0, op_count_o=0, ALU drive outputs idle.
- Reset asserted mid-EXEC or mid-EXEC2 aborts the operation; no response is produced after release.

Test Plan:
- ADD 0x7FFF + 0x0001 with out_ready_i=1 → alu_ctrl_o=0010 during EXEC; one cycle later result_o=0x8000, overflow_o=1, zero_o=0; ovf_sticky_o=1; op_count_o=1.
- SUB 0x0005 − 0x0005 → result_o=0x0000, zero_o=1, overflow_o=0. Follow with ovf_clr_i and a simultaneous overflowing ADD on the same edge → ovf_sticky_o stays 1.
- ABSDIFF A=0x0003, B=0x000A → EXEC ctrl 0111, EXEC2 ctrl 0110 with operands swapped; result_o=0x0007 two cycles after accept. Swapped operands (A=0x000A, B=0x0003) → 0x0007 with operands not swapped.
- MAX A=0xFFFE (−2), B=0x0001 → result_o=0x0001. MIN with same operands → 0xFFFE, overflow_o=0.
- Back-pressure: hold out_ready_i=0 across two requests → first response stays stable, in_ready_o=0. Raise out_ready_i → in_ready_o high the same cycle; second request accepted on that edge.
- Illegal op 0xF → err_o=1, result_o=0, zero_o=1. Separately, assert rst_i low during EXEC2 of a MIN → all outputs return to reset values; no out_valid_o after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/decode front end for the 16-bit ALU: decodes op classes, runs one or two ALU passes, registers the response.
// Latency: response valid 1 cycle after accept (single-pass, illegal) or 2 cycles (ABSDIFF/MAX/MIN).
// Backpressure: response held while out_ready_i is low; new requests are only accepted when idle and the output slot is free or draining.
module alu_issue_ctrl #(
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [W-1:0]     src1_i,
    input  logic [W-1:0]     src2_i,
    output logic [W-1:0]     alu_src1_o,
    output logic [W-1:0]     alu_src2_o,
    output logic [3:0]       alu_ctrl_o,
    input  logic [W-1:0]     alu_result_i,
    input  logic             alu_zero_i,
    input  logic             alu_overflow_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             err_o,
    output logic             ovf_sticky_o,
    input  logic             ovf_clr_i,
    output logic [CNT_W-1:0] op_count_o
);

    localparam logic [3:0] OP_AND     = 4'd0;
    localparam logic [3:0] OP_OR      = 4'd1;
    localparam logic [3:0] OP_ADD     = 4'd2;
    localparam logic [3:0] OP_SUB     = 4'd3;
    localparam logic [3:0] OP_NOR     = 4'd4;
    localparam logic [3:0] OP_NAND    = 4'd5;
    localparam logic [3:0] OP_SLT     = 4'd6;
    localparam logic [3:0] OP_ABSDIFF = 4'd8;
    localparam logic [3:0] OP_MAX     = 4'd9;
    localparam logic [3:0] OP_MIN     = 4'd10;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_NAND = 4'b1101;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, EXEC, EXEC2} state_t;

    state_t         state;
    logic [3:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           accept;
    logic           lt;

    function automatic logic is_dual(input logic [3:0] op);
        return (op == OP_ABSDIFF) || (op == OP_MAX) || (op == OP_MIN);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_SLT) || is_dual(op);
    endfunction

    function automatic logic [3:0] decode(input logic [3:0] op);
        case (op)
            OP_AND:  return CTRL_AND;
            OP_OR:   return CTRL_OR;
            OP_ADD:  return CTRL_ADD;
            OP_SUB:  return CTRL_SUB;
            OP_NOR:  return CTRL_NOR;
            OP_NAND: return CTRL_NAND;
            OP_SLT:  return CTRL_SLT;
            default: return CTRL_AND;
        endcase
    endfunction

    assign in_ready_o = (state == IDLE) && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    // SLT result bit from the first pass of a two-pass op selects the operand order
    assign lt         = alu_result_i[0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            alu_src1_o   <= '0;
            alu_src2_o   <= '0;
            alu_ctrl_o   <= CTRL_AND;
            out_valid_o  <= 1'b0;
            result_o     <= '0;
            zero_o       <= 1'b0;
            overflow_o   <= 1'b0;
            err_o        <= 1'b0;
            ovf_sticky_o <= 1'b0;
            op_count_o   <= '0;
        end else begin
            // Later assignments in this block (capture, sticky set) override these
            if (out_valid_o && out_ready_i)
                out_valid_o <= 1'b0;
            if (ovf_clr_i)
                ovf_sticky_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                        op_q  <= op_i;
                        a_q   <= src1_i;
                        b_q   <= src2_i;
                        if (is_legal(op_i)) begin
                            alu_src1_o <= src1_i;
                            alu_src2_o <= src2_i;
                            alu_ctrl_o <= is_dual(op_i) ? CTRL_SLT : decode(op_i);
                        end else begin
                            alu_src1_o <= '0;
                            alu_src2_o <= '0;
                            alu_ctrl_o <= CTRL_AND;
                        end
                    end
                end

                EXEC: begin
                    if (is_dual(op_q)) begin
                        state <= EXEC2;
                        case (op_q)
                            OP_ABSDIFF: begin
                                alu_ctrl_o <= CTRL_SUB;
                                alu_src1_o <= lt ? b_q : a_q;
                                alu_src2_o <= lt ? a_q : b_q;
                            end
                            OP_MAX: begin
                                alu_ctrl_o <= CTRL_OR;
                                alu_src1_o <= lt ? b_q : a_q;
                                alu_src2_o <= '0;
                            end
                            default: begin
                                alu_ctrl_o <= CTRL_OR;
                                alu_src1_o <= lt ? a_q : b_q;
                                alu_src2_o <= '0;
                            end
                        endcase
                    end else begin
                        state       <= IDLE;
                        alu_src1_o  <= '0;
                        alu_src2_o  <= '0;
                        alu_ctrl_o  <= CTRL_AND;
                        out_valid_o <= 1'b1;
                        op_count_o  <= op_count_o + CNT_ONE;
                        err_o       <= !is_legal(op_q);
                        if (is_legal(op_q)) begin
                            result_o   <= alu_result_i;
                            zero_o     <= alu_zero_i;
                            overflow_o <= alu_overflow_i;
                            if (alu_overflow_i && (op_q == OP_ADD || op_q == OP_SUB))
                                ovf_sticky_o <= 1'b1;
                        end else begin
                            result_o   <= '0;
                            zero_o     <= 1'b1;
                            overflow_o <= 1'b0;
                        end
                    end
                end

                EXEC2: begin
                    state       <= IDLE;
                    alu_src1_o  <= '0;
                    alu_src2_o  <= '0;
                    alu_ctrl_o  <= CTRL_AND;
                    out_valid_o <= 1'b1;
                    op_count_o  <= op_count_o + CNT_ONE;
                    err_o       <= 1'b0;
                    result_o    <= alu_result_i;
                    zero_o      <= alu_zero_i;
                    // MAX/MIN second pass is an OR with zero; its flag is meaningless
                    overflow_o  <= (op_q == OP_ABSDIFF) && alu_overflow_i;
                    if ((op_q == OP_ABSDIFF) && alu_overflow_i)
                        ovf_sticky_o <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
